// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the int8 MAC sequencer
package mac_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESULT} state_t;

  localparam int PSUM_W        = 24;
  localparam int LANES_DEFAULT = 33;

endpackage

// File: rtl/int8_mac_seq.sv
// rtl/int8_mac_seq.sv - feeds operand chunks into the int8 MAC and accumulates one result per job
module int8_mac_seq
  import mac_pkg::*;
#(
  parameter int LANES   = LANES_DEFAULT,
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_chunks,
  output logic                busy,
  output logic                done,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [LANES*8-1:0]  op_a,
  input  logic [LANES*8-1:0]  op_b,
  output logic                mac_en,
  output logic [LANES*8-1:0]  mac_a,
  output logic [LANES*8-1:0]  mac_b,
  output logic [PSUM_W-1:0]   mac_psum_in,
  input  logic [PSUM_W-1:0]   mac_psum_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PSUM_W-1:0]   res_data
);

  localparam logic [3:0] LP_LAT = 4'(MAC_LAT);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_left;
  logic [3:0]           r_wcnt;
  logic [PSUM_W-1:0]    r_acc;
  logic [LANES*8-1:0]   r_mac_a;
  logic [LANES*8-1:0]   r_mac_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_chunks != '0) ? FETCH : RESULT;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        op_ready = 1'b1;
        if (op_valid) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (r_wcnt == 4'd0) begin
          w_next = (r_left == CNT_W'(1)) ? RESULT : FETCH;
        end
      end
      RESULT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          done   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // MAC inputs stay frozen for the whole WAIT phase so the MAC output settles cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left  <= '0;
      r_wcnt  <= '0;
      r_acc   <= '0;
      r_mac_a <= '0;
      r_mac_b <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_left <= num_chunks;
            r_acc  <= '0;
          end
        end
        FETCH: begin
          if (op_valid) begin
            r_mac_a <= op_a;
            r_mac_b <= op_b;
            r_wcnt  <= LP_LAT;
          end
        end
        WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_acc  <= mac_psum_out;
            r_left <= r_left - CNT_W'(1);
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mac_en      = busy;
  assign mac_a       = r_mac_a;
  assign mac_b       = r_mac_b;
  assign mac_psum_in = r_acc;
  assign res_data    = r_acc;

endmodule

// File: tb/tb_int8_mac_seq.sv
// tb/tb_int8_mac_seq.sv - scoreboard bench for int8_mac_seq with a behavioural MAC alongside
module tb_int8_mac_seq;

  localparam int LANES   = 33;
  localparam int W       = LANES * 8;
  localparam int MAC_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    num_chunks;
  logic          busy, done, op_valid, op_ready, mac_en, res_valid, res_ready;
  logic [W-1:0]  op_a, op_b, mac_a, mac_b;
  logic [23:0]   mac_psum_in, mac_psum_out, res_data;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int op_ready_cnt = 0;
  logic [23:0] sb_q[$];
  int ja[0:31];
  int jb[0:31];

  int8_mac_seq #(.LANES(LANES), .MAC_LAT(MAC_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
    .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [23:0] dot(input logic [W-1:0] a, input logic [W-1:0] b);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return 24'(s);
  endfunction

  // Neighbouring MAC: psum_in + dot(a,b), settled MAC_LAT edges after its inputs change.
  logic [23:0] m_p0, m_p1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p0 <= '0;
      m_p1 <= '0;
    end else begin
      m_p0 <= mac_psum_in + dot(mac_a, mac_b);
      m_p1 <= m_p0;
    end
  end
  assign mac_psum_out = m_p1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (op_ready) op_ready_cnt <= op_ready_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (res_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        end else begin
          check("res_data", 32'(res_data), 32'(sb_q.pop_front()));
          check("done_on_handshake", 32'(done), 32'd1);
        end
      end else begin
        check("done_while_held", 32'(done), 32'd0);
        if (sb_q.size() > 0) check("res_data_held", 32'(res_data), 32'(sb_q[0]));
      end
    end
  end

  task automatic wait_op_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (op_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("op_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_job(input int n, input int gap, input bit hold, input bit stray,
                         input logic [23:0] exp_res);
    int c0, stall, rdy0;
    bit ok;
    logic [23:0] pre;
    logic [W-1:0] ea;
    sb_q.push_back(exp_res);
    @(posedge clk); #1;
    res_ready  = !hold;
    start      = 1'b1;
    num_chunks = 8'(n);
    c0   = cyc;
    rdy0 = op_ready_cnt;
    @(posedge clk); #1;
    start      = 1'b0;
    num_chunks = 8'hAA;
    pre   = '0;
    stall = 0;
    for (int k = 0; k < n; k++) begin
      op_a = fill(ja[k]);
      op_b = fill(jb[k]);
      if (gap > 0 && k > 0) begin
        op_valid = 1'b0;
        wait_op_ready();
        if (stray) begin
          start      = 1'b1;
          num_chunks = 8'd7;
        end
        repeat (gap) @(posedge clk);
        #1;
        start = 1'b0;
        stall += gap;
      end
      op_valid = 1'b1;
      wait_op_ready();
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      check("psum_in_wait", 32'(mac_psum_in), 32'(pre));
      ea = fill(ja[k]);
      check("mac_a_latched", 32'(mac_a == ea), 32'd1);
      pre = pre + dot(fill(ja[k]), fill(jb[k]));
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("res_valid_timeout", 32'(ok), 32'd1);
    check("latency", 32'(cyc - c0), 32'(1 + n * (MAC_LAT + 2) + stall));
    if (n == 0) check("op_ready_never", 32'(op_ready_cnt - rdy0), 32'd0);
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_job", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_chunks = '0;
    op_valid   = 1'b0;
    op_a       = '0;
    op_b       = '0;
    res_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_psum_in", 32'(mac_psum_in), 32'd0);
    check("rst_mac_ab_zero", 32'((mac_a | mac_b) == '0), 32'd1);
    rst_n = 1'b1;

    ja[0] = 1;  jb[0] = 2;
    run_job(1, 0, 1'b0, 1'b0, 24'd66);

    ja[1] = -1; jb[1] = 3;
    ja[2] = 4;  jb[2] = 4;
    run_job(3, 0, 1'b0, 1'b0, 24'd495);
    run_job(0, 0, 1'b0, 1'b0, 24'd0);
    run_job(3, 3, 1'b0, 1'b1, 24'd495);
    run_job(1, 0, 1'b1, 1'b0, 24'd66);

    for (int k = 0; k < 32; k++) begin
      ja[k] = 127;
      jb[k] = 127;
    end
    run_job(2, 0, 1'b0, 1'b0, 24'd1064514);
    run_job(32, 0, 1'b0, 1'b0, 24'd255008);

    // Abort a three-chunk job during the second chunk's WAIT.
    @(posedge clk); #1;
    start      = 1'b1;
    num_chunks = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_a     = fill(5);
      op_b     = fill(6);
      op_valid = 1'b1;
      wait_op_ready();
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    #2;
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_ready", 32'(op_ready), 32'd0);
    check("abort_mac_en", 32'(mac_en), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_psum_in", 32'(mac_psum_in), 32'd0);
    check("abort_mac_ab_zero", 32'((mac_a | mac_b) == '0), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      ja[k] = 1;
      jb[k] = 2;
    end
    run_job(1, 0, 1'b0, 1'b0, 24'd66);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int8_mac_seq.md
# int8_mac_seq

Sequencer for the 33-lane int8 dot-product MAC: accepts a job of N operand chunks, streams each chunk into the MAC, and feeds the running 24-bit partial sum back. It returns one accumulated result per job. It sits between the operand buffer, which supplies chunks through a valid/ready stream, and the result sink, which is a valid/ready stream with backpressure. The `int8_mac` instance sits beside it.

## Interface
- `LANES`, default 33: int8 elements per chunk; vector width is `LANES*8` (264).
- `MAC_LAT`, default 2: number of clock edges after `mac_a`/`mac_b` update until `mac_psum_out` is settled; range 1..15.
- `CNT_W`, default 8: width of the chunk count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `num_chunks` in CNT_W: chunks in the job; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on the result handshake.
- `op_valid` in 1 / `op_ready` out 1: operand stream handshake.
- `op_a`, `op_b` in LANES*8: operand chunk; element i is at `[8i+7:8i]`, signed.
- `mac_en` out 1: drives the MAC's `int8_en`; equals `busy`.
- `mac_a`, `mac_b` out LANES*8: registered operands to the MAC.
- `mac_psum_in` out 24: running accumulator to the MAC.
- `mac_psum_out` in 24: MAC result.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_data` out 24: accumulated result.

## Operation
States are IDLE, FETCH, WAIT and RESULT.

- **Reset:** state goes to IDLE. Every output is 0: `busy`, `done`, `op_ready`, `mac_en`, `mac_a`, `mac_b`, `mac_psum_in`, `res_valid`, `res_data`. The internal accumulator and both counters are also 0.
- **IDLE:**
  - With `start`=1, latch `num_chunks` into `left` and clear `acc` to 0.
  - If `num_chunks`≠0, go to FETCH; if `num_chunks`=0, go straight to RESULT with `res_data`=0.
  - `start` outside IDLE is ignored; it is neither queued nor an error.
- **FETCH:**
  - `op_ready`=1, driven from the state.
  - On `op_valid&&op_ready`: `mac_a`<=`op_a`, `mac_b`<=`op_b`, `wcnt`<=`MAC_LAT`, go to WAIT.
- **WAIT:**
  - `op_ready`=0. `mac_a`, `mac_b` and `mac_psum_in` are held stable.
  - `wcnt` decrements each cycle. In the cycle where `wcnt`=0: `acc`<=`mac_psum_out` and `left`<=`left`-1.
  - If the old `left` was 1, go to RESULT; otherwise go to FETCH.
- **RESULT:**
  - `res_valid`=1 and `res_data`=`acc`, both held until `res_ready`.
  - On the handshake: `done`=1 for that cycle only, `res_valid` drops at the next edge, and the state returns to IDLE.
- **Accumulator wiring:** `mac_psum_in` is wired to `acc`. Arithmetic is 24-bit two's complement and wraps silently, matching the MAC; no saturation and no overflow flag.

## Timing
- Start to first FETCH: 1 cycle.
- Per chunk: at least 1 FETCH cycle plus `MAC_LAT`+1 WAIT cycles, so `MAC_LAT`+2 cycles when `op_valid` is held high (4 cycles at default).
- If the operand handshake is at edge E0, `acc` updates at edge E0+`MAC_LAT`+1.
- Job latency with no stalls: 1 + N·(`MAC_LAT`+2) cycles to `res_valid`. A job with N=0 reaches `res_valid` 1 cycle after start.
- A stall on `op_valid` extends FETCH only. `res_ready` low holds RESULT indefinitely.
- Back-to-back jobs: `start` is accepted at the earliest in the cycle after `done`.
- Reset asserted mid-job: the job is aborted immediately and asynchronously, with no result and no `done`. A partially consumed operand stream is the producer's responsibility to flush.

## Structure
- Shared package `mac_pkg`:
  - the state enum `{IDLE, FETCH, WAIT, RESULT}`;
  - the constant `PSUM_W`=24;
  - the default `LANES`=33.
- No sub-module. `wcnt` and `left` are plain counters in the same module; the MAC is instantiated by the parent, not here.

## Test plan
- **Single chunk:** N=1, all `a` lanes =1, all `b` lanes =2, `MAC_LAT`=2. Expect `res_data`=66 at 5 cycles after start and a 1-cycle `done`.
- **Multi-chunk accumulate:** N=3, chunks give 66, then `a`=-1/`b`=3 giving -99, then `a`=4/`b`=4 giving 528. Expect `res_data`=495. Check `mac_psum_in` equals 0, 66 and -33 during the three WAIT phases.
- **N=0:** expect `res_valid` with `res_data`=0 one cycle after start, and `op_ready` never asserted.
- **Backpressure and stalls:**
  - Gap `op_valid` low for 3 cycles between chunks: the result is unchanged and latency grows by 3.
  - Hold `res_ready` low for 5 cycles: `res_data` is stable and `done` fires only on the handshake.
- **Wrap:** N=2, each chunk all lanes 127×127 (sum 532257). Expect `res_data`=1064514 mod 2^24 = 1064514. Then a third chunk of 127×127 with N=32, expecting 17032224 mod 2^24 = 255008.
- **Reset mid-job and ignored start:**
  - Assert `rst_n`=0 during WAIT of chunk 2: all outputs read 0 immediately and the state is IDLE.
  - A new job then yields a correct result.
  - `start` pulsed during FETCH is ignored.
